// File: rtl/megasys1_loader_pkg.sv
// Shared types for the Mega System 1 ROM loader: the queued SDRAM word,
// the issue FSM states and the byte-enable encodings.
package megasys1_loader_pkg;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } rom_word_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [1:0] BE_BOTH = 2'b11;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_LO   = 2'b01;

endpackage

// File: rtl/megasys1_rom_loader_fifo.sv
// Small synchronous word FIFO between the byte packer and the SDRAM issuer.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module loader_fifo
    import megasys1_loader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  rom_word_t din_i,
    input  logic      pop_i,
    output rom_word_t dout_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);

    rom_word_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/megasys1_rom_loader.sv
// Packs the ioctl byte stream into big-endian 16-bit words and writes them to
// SDRAM one at a time over a toggle req/ack handshake.
module megasys1_rom_loader
    import megasys1_loader_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter logic [23:0] BASE_WORD  = 24'h000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic [23:0] sdram_addr,
    output logic [15:0] sdram_din,
    output logic [1:0]  sdram_be,
    output logic        loader_busy,
    output logic        rom_loaded,
    output logic        overflow
);
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [23:0] pend_addr_q, pend_addr_d;
    logic        push_vld_q, push_vld_d;
    rom_word_t   push_word_q, push_word_d;
    logic        skid_vld_q, skid_vld_d;
    rom_word_t   skid_word_q, skid_word_d;

    state_t      state_q;
    logic        req_q;
    logic [23:0] addr_q;
    logic [15:0] din_q;
    logic [1:0]  be_q;
    logic        dl_q;
    logic        loaded_q;
    logic        ovf_q;

    logic        accept;
    logic [23:0] byte_waddr;
    rom_word_t   pend_word;
    rom_word_t   fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        dl_rise;
    logic        busy;

    function automatic rom_word_t mk_word(input logic [23:0] waddr,
                                          input logic [15:0] data,
                                          input logic [1:0]  be);
        rom_word_t w;
        w.addr = BASE_WORD + waddr;
        w.data = data;
        w.be   = be;
        return w;
    endfunction

    // A byte arriving while the skid register is occupied cannot happen given
    // the guaranteed ioctl_wr spacing, so accept is simply gated off.
    assign accept     = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX) && !skid_vld_q;
    assign byte_waddr = ioctl_addr[24:1];
    assign pend_word  = mk_word(pend_addr_q, {pend_data_q, 8'h00}, BE_HI);

    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        pend_addr_d = pend_addr_q;
        push_vld_d  = 1'b0;
        push_word_d = push_word_q;
        skid_vld_d  = skid_vld_q;
        skid_word_d = skid_word_q;
        if (skid_vld_q) begin
            push_vld_d  = 1'b1;
            push_word_d = skid_word_q;
            skid_vld_d  = 1'b0;
        end else if (accept) begin
            if (!ioctl_addr[0]) begin
                if (pend_vld_q) begin
                    push_vld_d  = 1'b1;
                    push_word_d = pend_word;
                end
                pend_vld_d  = 1'b1;
                pend_data_d = ioctl_dout;
                pend_addr_d = byte_waddr;
            end else if (pend_vld_q && (pend_addr_q == byte_waddr)) begin
                push_vld_d  = 1'b1;
                push_word_d = mk_word(byte_waddr, {pend_data_q, ioctl_dout}, BE_BOTH);
                pend_vld_d  = 1'b0;
            end else if (pend_vld_q) begin
                push_vld_d  = 1'b1;
                push_word_d = pend_word;
                skid_vld_d  = 1'b1;
                skid_word_d = mk_word(byte_waddr, {8'h00, ioctl_dout}, BE_LO);
                pend_vld_d  = 1'b0;
            end else begin
                push_vld_d  = 1'b1;
                push_word_d = mk_word(byte_waddr, {8'h00, ioctl_dout}, BE_LO);
            end
        end else if (!ioctl_download && pend_vld_q) begin
            // Download finished on an even byte: flush it as a high-byte write.
            push_vld_d  = 1'b1;
            push_word_d = pend_word;
            pend_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            pend_addr_q <= '0;
            push_vld_q  <= 1'b0;
            push_word_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_word_q <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            pend_addr_q <= pend_addr_d;
            push_vld_q  <= push_vld_d;
            push_word_q <= push_word_d;
            skid_vld_q  <= skid_vld_d;
            skid_word_q <= skid_word_d;
        end
    end

    loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .push_i  (push_vld_q),
        .din_i   (push_word_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign fifo_pop = (state_q == IDLE) && !fifo_empty;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        addr_q  <= fifo_dout.addr;
                        din_q   <= fifo_dout.data;
                        be_q    <= fifo_dout.be;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    req_q   <= ~req_q;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (sdram_ack == req_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dl_rise = ioctl_download && !dl_q;
    // The push register counts as busy so a word in flight to the FIFO is never missed.
    assign busy    = !fifo_empty || pend_vld_q || skid_vld_q || push_vld_q || (state_q != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q     <= 1'b0;
            loaded_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise)
                loaded_q <= 1'b0;
            else if (!ioctl_download && !busy)
                loaded_q <= 1'b1;
            if (push_vld_q && fifo_full && !fifo_pop)
                ovf_q <= 1'b1;
            else if (dl_rise)
                ovf_q <= 1'b0;
        end
    end

    assign sdram_req   = req_q;
    assign sdram_addr  = addr_q;
    assign sdram_din   = din_q;
    assign sdram_be    = be_q;
    assign loader_busy = busy;
    assign rom_loaded  = loaded_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_megasys1_rom_loader.sv
// Scoreboard bench for megasys1_rom_loader: expected SDRAM writes are queued
// as bytes are driven and compared as each req toggle appears.
module tb_megasys1_rom_loader;
    import megasys1_loader_pkg::*;

    localparam logic [23:0] BASE = 24'h100000;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        sdram_ack = 1'b0;
    logic        sdram_req;
    logic [23:0] sdram_addr;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_be;
    logic        loader_busy;
    logic        rom_loaded;
    logic        overflow;

    int          n_cmp = 0;
    int          n_bad = 0;
    rom_word_t   exp_q[$];
    rom_word_t   mon_e;
    logic        req_seen = 1'b0;
    logic        ack_stall = 1'b0;
    int          ack_delay = 3;
    logic        busy_seen;

    megasys1_rom_loader #(
        .ROM_INDEX  (8'd0),
        .BASE_WORD  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .sdram_req      (sdram_req),
        .sdram_ack      (sdram_ack),
        .sdram_addr     (sdram_addr),
        .sdram_din      (sdram_din),
        .sdram_be       (sdram_be),
        .loader_busy    (loader_busy),
        .rom_loaded     (rom_loaded),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_wr(input logic [23:0] word, input logic [15:0] data, input logic [1:0] be);
        rom_word_t w;
        w.addr = BASE + word;
        w.data = data;
        w.be   = be;
        exp_q.push_back(w);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic dl_start(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick(2);
        check("loaded_clr_on_start", 32'(rom_loaded), 32'd0);
        check("ovf_clr_on_start", 32'(overflow), 32'd0);
    endtask

    task automatic dl_end();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
    endtask

    task automatic wait_loaded(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            if (rom_loaded) break;
        end
        check({tag, "_loaded"}, 32'(rom_loaded), 32'd1);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Write monitor: every req toggle is one SDRAM write.
    always @(negedge clk_sys) begin
        if (reset) begin
            req_seen = sdram_req;
        end else if (sdram_req != req_seen) begin
            req_seen = sdram_req;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {8'h00, sdram_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(sdram_addr), 32'(mon_e.addr));
                check("wr_data", 32'(sdram_din), 32'(mon_e.data));
                check("wr_be", 32'(sdram_be), 32'(mon_e.be));
            end
        end
    end

    // SDRAM controller model: ack follows req after ack_delay cycles unless stalled.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (reset) begin
                sdram_ack = 1'b0;
                cnt = 0;
            end else if (!ack_stall && (sdram_ack != sdram_req)) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    sdram_ack = sdram_req;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_din", 32'(sdram_din), 32'd0);
        check("rst_be", 32'(sdram_be), 32'd0);
        check("rst_busy", 32'(loader_busy), 32'd0);
        check("rst_loaded", 32'(rom_loaded), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        tick(2);

        // Four contiguous bytes -> two full words.
        dl_start(8'd0);
        expect_wr(24'd0, 16'h1234, BE_BOTH);
        expect_wr(24'd1, 16'h5678, BE_BOTH);
        send_byte(25'd0, 8'h12);
        send_byte(25'd1, 8'h34);
        send_byte(25'd2, 8'h56);
        send_byte(25'd3, 8'h78);
        dl_end();
        wait_loaded("t1");

        // Odd length: trailing even byte flushed at download end.
        dl_start(8'd0);
        expect_wr(24'd0, 16'hAABB, BE_BOTH);
        expect_wr(24'd1, 16'hCC00, BE_HI);
        send_byte(25'd0, 8'hAA);
        send_byte(25'd1, 8'hBB);
        send_byte(25'd2, 8'hCC);
        tick(4);
        check("t2_pending_busy", 32'(loader_busy), 32'd1);
        dl_end();
        wait_loaded("t2");

        // Non-contiguous bytes: pending high byte, then lone low byte via skid.
        dl_start(8'd0);
        expect_wr(24'd2, 16'h1100, BE_HI);
        expect_wr(24'd4, 16'h0022, BE_LO);
        send_byte(25'd4, 8'h11);
        send_byte(25'd9, 8'h22);
        dl_end();
        wait_loaded("t3");

        // Stalled ack: one word in flight plus a full FIFO, rest dropped.
        dl_start(8'd0);
        ack_stall = 1'b1;
        for (int k = 0; k < 5; k++)
            expect_wr(24'(k), {8'(2*k+1), 8'(2*k+2)}, BE_BOTH);
        for (int i = 0; i < 10; i++)
            send_byte(25'(i), 8'(i+1));
        tick(3);
        check("t4_no_ovf_at_capacity", 32'(overflow), 32'd0);
        send_byte(25'd10, 8'd11);
        send_byte(25'd11, 8'd12);
        tick(2);
        check("t4_ovf_set", 32'(overflow), 32'd1);
        for (int i = 12; i < 16; i++)
            send_byte(25'(i), 8'(i+1));
        tick(150);
        check("t4_busy_stalled", 32'(loader_busy), 32'd1);
        ack_stall = 1'b0;
        dl_end();
        wait_loaded("t4");
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Foreign index: nothing written, never busy.
        dl_start(8'd1);
        busy_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(25'(i), 8'(8'h40 + i));
            busy_seen = busy_seen | loader_busy;
        end
        check("t5_busy_never", 32'(busy_seen), 32'd0);
        dl_end();
        wait_loaded("t5");

        // Reset while waiting on ack with two words queued.
        dl_start(8'd0);
        ack_stall = 1'b1;
        expect_wr(24'd0, 16'hA0A1, BE_BOTH);
        for (int i = 0; i < 6; i++)
            send_byte(25'(i), 8'(8'hA0 + i));
        tick(3);
        check("t6_busy_before_rst", 32'(loader_busy), 32'd1);
        check("t6_first_issued", 32'(exp_q.size()), 32'd0);
        @(negedge clk_sys);
        reset = 1'b1;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("t6_rst_req", 32'(sdram_req), 32'd0);
        check("t6_rst_addr", 32'(sdram_addr), 32'd0);
        check("t6_rst_din", 32'(sdram_din), 32'd0);
        check("t6_rst_be", 32'(sdram_be), 32'd0);
        check("t6_rst_busy", 32'(loader_busy), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        check("t6_rst_fifo_empty", 32'(dut.fifo_empty), 32'd1);
        ack_stall = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        tick(2);
        dl_start(8'd0);
        check("t6_req_restart", 32'(sdram_req), 32'd0);
        expect_wr(24'd8, 16'h5AA5, BE_BOTH);
        expect_wr(24'd9, 16'hC33C, BE_BOTH);
        send_byte(25'd16, 8'h5A);
        send_byte(25'd17, 8'hA5);
        send_byte(25'd18, 8'hC3);
        send_byte(25'd19, 8'h3C);
        dl_end();
        wait_loaded("t6");
        check("t6_req_after_two", 32'(sdram_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
